// File: rtl/line_burst_adapter.sv
// line_burst_adapter: turns single 256-bit line requests into four-beat 64-bit bursts toward memory
module line_burst_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [31:0]       burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int BW = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_nx;
    logic [BW-1:0]     beat;
    logic [LINE_W-1:0] line_q;
    logic              last;
    logic              unused_addr;

    assign unused_addr   = ^pmem_address[4:0];
    assign last          = beat == BW'(BEATS - 1);
    assign burst_read    = state == RD;
    assign burst_write   = state == WR;
    assign pmem_resp     = state == DONE;
    assign burst_wdata   = (state == WR) ? line_q[beat*BEAT_W +: BEAT_W] : '0;

    // next-state: write wins on accept, last acknowledged beat ends the burst
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = pmem_write ? WR : pmem_read ? RD : IDLE;
            RD, WR: state_nx = (burst_resp && last) ? DONE : state;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, latched request, beat counter and read-line assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= '0;
            line_q        <= '0;
            pmem_rdata    <= '0;
            burst_address <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (pmem_read || pmem_write)) begin
                burst_address <= {pmem_address[31:5], 5'b0};
                beat          <= '0;
            end
            if (state == IDLE && pmem_write)
                line_q <= pmem_wdata;
            if ((state == RD || state == WR) && burst_resp)
                beat <= beat + BW'(1);
            if (state == RD && burst_resp)
                pmem_rdata[beat*BEAT_W +: BEAT_W] <= burst_rdata;
        end
    end
endmodule

// File: tb/tb_line_burst_adapter.sv
// tb_line_burst_adapter: table-driven line transactions plus reset and stray-ack corner cases
module tb_line_burst_adapter;
    logic         clk = 0;
    logic         rst_n = 0;
    logic [31:0]  pmem_address = 0;
    logic         pmem_read = 0;
    logic         pmem_write = 0;
    logic [255:0] pmem_wdata = 0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata = 0;
    logic         burst_resp = 0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wline;
        logic [255:0] rline;
        int           gap;
        logic [31:0]  exp_addr;
        logic [255:0] exp_rdata;
        int           exp_lat;
    } vec_t;

    vec_t vecs[5];
    vec_t v_new;

    line_burst_adapter dut (
        .clk(clk), .rst_n(rst_n),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
        .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drives one request and acts as a memory that acks every (gap+1) cycles
    task automatic run_txn(input vec_t v);
        int cyc, k, w;
        logic done;
        @(negedge clk);
        pmem_address = v.addr;
        pmem_read = v.rd;
        pmem_write = v.wr;
        pmem_wdata = v.wline;
        k = 0; w = v.gap; done = 0; cyc = 0;
        while (!done && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            burst_resp = 0;
            if (pmem_resp) begin
                done = 1;
                chk("latency", cyc, v.exp_lat);
                chk("beats", k, 4);
                chk("rdata", pmem_rdata, v.exp_rdata);
                chk("addr", burst_address, v.exp_addr);
                pmem_read = 0;
                pmem_write = 0;
            end else if (k < 4) begin
                chk("dir", {burst_read, burst_write}, v.wr ? 2'b01 : 2'b10);
                if (burst_write) chk("wdata", burst_wdata, v.wline[k*64 +: 64]);
                if (w >= v.gap) begin
                    burst_resp = 1;
                    burst_rdata = v.rline[k*64 +: 64];
                    k++;
                    w = 0;
                end else w++;
            end
        end
        if (!done) begin
            chk("timeout", 0, 1);
            pmem_read = 0;
            pmem_write = 0;
        end
        @(posedge clk); #1;
        chk("resp_pulse", pmem_resp, 0);
        chk("idle_dir", {burst_read, burst_write}, 0);
    endtask

    initial begin
        logic [255:0] r0, r2, r4, w1, w3, junk;
        r0 = {64'hDEAD_BEEF_0000_00A3, 64'hDEAD_BEEF_0000_00A2, 64'hDEAD_BEEF_0000_00A1, 64'hDEAD_BEEF_0000_00A0};
        w1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        r2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        w3 = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002, 64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
        r4 = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
        junk = {4{64'hFFFF_FFFF_FFFF_FFFF}};
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'h0, r0,   0, 32'h0000_1220, r0, 5};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0080, w1,     junk, 1, 32'h0000_0080, r0, 8};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 256'h0, r2,   3, 32'hFFFF_FFE0, r2, 14};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0040, w3,     junk, 0, 32'h0000_0040, r2, 5};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 256'h0, r4,   2, 32'h0000_0000, r4, 11};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {pmem_resp, burst_read, burst_write, burst_address, burst_wdata}, 0);
        chk("reset_rdata", pmem_rdata, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // stray acknowledges in IDLE must change nothing
        @(negedge clk);
        burst_resp = 1;
        burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (2) @(posedge clk);
        #1;
        burst_resp = 0;
        chk("stray_rdata", pmem_rdata, r4);
        chk("stray_outs", {pmem_resp, burst_read, burst_write}, 0);

        // reset after three beats of a read abandons it
        @(negedge clk);
        pmem_address = 32'h0000_2000;
        pmem_read = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            burst_resp = 1;
            burst_rdata = 64'h7777_0000_0000_0000 | 64'(k);
        end
        @(posedge clk); #1;
        burst_resp = 0;
        chk("mid_read", burst_read, 1);
        @(negedge clk);
        pmem_read = 0;
        rst_n = 0;
        #1;
        chk("async_outs", {pmem_resp, burst_read, burst_write, burst_address, burst_wdata}, 0);
        chk("async_rdata", pmem_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        v_new = '{1'b1, 1'b0, 32'h0000_3000, 256'h0, r2, 0, 32'h0000_3000, r2, 5};
        run_txn(v_new);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
